// File: rtl/hazard_pkg.sv
// Shared types for the RV32I pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle; master is the datapath, slave the controller.
interface hazard_ctrl_if #(parameter int REG_ADDR_W = 5);
  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                  RegWriteM, RegWriteW;
  logic [1:0]            ResultSrcE;
  logic                  PCSrcE, MemAccessM, MemReadyM;
  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE, FlushW;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  MemReqM, MemErr;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemAccessM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemReqM, MemErr
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemAccessM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemReqM, MemErr
  );
endinterface

// File: rtl/hazard_ctrl_forward_sel.sv
// One-operand forwarding mux select; M result beats W, x0 never forwarded.
module forward_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rdm,
  input  logic [REG_ADDR_W-1:0] rdw,
  input  logic                  regwritem,
  input  logic                  regwritew,
  output fwd_sel_t              fwd
);
  always_comb begin
    fwd = FWD_RF;
    if (regwritem && rdm != '0 && rdm == rs)      fwd = FWD_M;
    else if (regwritew && rdw != '0 && rdw == rs) fwd = FWD_W;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control plus M-stage memory wait FSM with timeout.
// HAZARD_STATS_EN adds saturating cycle counters for load-use, mem-wait and flush.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave hif
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StatLoadUse,
  output logic [31:0] StatMemWait,
  output logic [31:0] StatFlush
`endif
);
  mem_state_t state;
  logic [CNT_W-1:0] cnt;
  logic mem_err;
  logic mstall, lu, br;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hif.MemAccessM && !hif.MemReadyM) begin
          state <= WAIT;
          cnt   <= CNT_W'(1);
        end
        WAIT: begin
          if (hif.MemReadyM) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            state   <= IDLE;
            cnt     <= '0;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below is gated by rst_n so the pipeline sees a quiet controller in reset.
  always_comb begin
    mstall = rst_n && !hif.MemReadyM &&
             ((state == IDLE && hif.MemAccessM) || state == WAIT);
    lu     = rst_n && !mstall && hif.ResultSrcE == RESULT_SRC_LOAD && hif.RdE != '0 &&
             (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
    br     = rst_n && !mstall && hif.PCSrcE;
  end

  assign hif.StallF  = mstall | lu;
  assign hif.StallD  = mstall | lu;
  assign hif.StallE  = mstall;
  assign hif.StallM  = mstall;
  assign hif.FlushW  = mstall;
  assign hif.FlushD  = br;
  assign hif.FlushE  = lu | br;
  assign hif.MemReqM = rst_n && ((state == IDLE && hif.MemAccessM) || state == WAIT);
  assign hif.MemErr  = mem_err;

  logic [1:0][REG_ADDR_W-1:0] rs_e;
  fwd_sel_t [1:0]             fwd;
  assign rs_e = {hif.Rs2E, hif.Rs1E};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
      .rs(rs_e[i]), .rdm(hif.RdM), .rdw(hif.RdW),
      .regwritem(hif.RegWriteM), .regwritew(hif.RegWriteW), .fwd(fwd[i])
    );
  end

  assign hif.ForwardAE = rst_n ? fwd[0] : FWD_RF;
  assign hif.ForwardBE = rst_n ? fwd[1] : FWD_RF;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StatLoadUse <= '0;
      StatMemWait <= '0;
      StatFlush   <= '0;
    end else begin
      if (lu)     StatLoadUse <= sat_inc(StatLoadUse);
      if (mstall) StatMemWait <= sat_inc(StatMemWait);
      if (br)     StatFlush   <= sat_inc(StatFlush);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, memory wait/timeout, reset.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(5)) hif ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_lu, stat_mw, stat_fl;
`endif

  hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .hif(hif.slave)
`ifdef HAZARD_STATS_EN
    , .StatLoadUse(stat_lu), .StatMemWait(stat_mw), .StatFlush(stat_fl)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
    hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
    hif.RegWriteM = 0; hif.RegWriteW = 0; hif.ResultSrcE = 0;
    hif.PCSrcE = 0; hif.MemAccessM = 0; hif.MemReadyM = 0;
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {hif.StallF, hif.StallD, hif.StallE, hif.StallM,
              hif.FlushD, hif.FlushE, hif.FlushW}, {25'd0, exp});
  endtask

  initial begin
    clr();
    tick(); tick();
    // outputs must be quiet in reset even with active inputs
    hif.MemAccessM = 1; hif.PCSrcE = 1; hif.RegWriteM = 1; hif.RdM = 3; hif.Rs1E = 3;
    #1;
    chk_ctl("rst_ctl", 7'b0000000);
    chk("rst_req", hif.MemReqM, 0);
    chk("rst_fwda", hif.ForwardAE, 0);
    chk("rst_err", hif.MemErr, 0);
    tick();
    clr(); rst_n = 1; #1;
    chk_ctl("idle_ctl", 7'b0000000);

    // forwarding
    hif.RegWriteM = 1; hif.RdM = 5; hif.RegWriteW = 1; hif.RdW = 5;
    hif.Rs1E = 5; hif.Rs2E = 5; #1;
    chk("fwd_mprio_a", hif.ForwardAE, 2'b10);
    chk("fwd_mprio_b", hif.ForwardBE, 2'b10);
    hif.RegWriteM = 0; #1;
    chk("fwd_w_a", hif.ForwardAE, 2'b01);
    hif.RegWriteM = 1; hif.RdM = 0; hif.RdW = 0; hif.Rs1E = 0; hif.Rs2E = 0; #1;
    chk("fwd_x0_a", hif.ForwardAE, 2'b00);
    chk("fwd_x0_b", hif.ForwardBE, 2'b00);
    hif.RdM = 3; hif.RdW = 4; hif.Rs1E = 4; hif.Rs2E = 3; #1;
    chk("fwd_split_a", hif.ForwardAE, 2'b01);
    chk("fwd_split_b", hif.ForwardBE, 2'b10);
    hif.RegWriteW = 0; #1;
    chk("fwd_nowr_a", hif.ForwardAE, 2'b00);
    clr();

    // load-use
    hif.ResultSrcE = 2'b01; hif.RdE = 7; hif.Rs2D = 7; #1;
    chk_ctl("lu_hit", 7'b1100010);
    tick();
    hif.ResultSrcE = 2'b00; hif.RdE = 0; #1;
    chk_ctl("lu_bubble", 7'b0000000);
    hif.ResultSrcE = 2'b01; hif.RdE = 0; hif.Rs1D = 0; hif.Rs2D = 0; #1;
    chk_ctl("lu_x0", 7'b0000000);
    hif.ResultSrcE = 2'b10; hif.RdE = 7; hif.Rs2D = 7; #1;
    chk_ctl("lu_notload", 7'b0000000);
    clr();

    // branch, then branch combined with load-use
    hif.PCSrcE = 1; #1;
    chk_ctl("br", 7'b0000110);
    hif.ResultSrcE = 2'b01; hif.RdE = 9; hif.Rs1D = 9; #1;
    chk_ctl("br_lu", 7'b1100110);

    // 3-cycle memory wait; held branch and load-use are overridden
    hif.MemAccessM = 1; hif.MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_ctl%0d", i), {hif.MemReqM, hif.StallF, hif.StallD, hif.StallE,
          hif.StallM, hif.FlushD, hif.FlushE, hif.FlushW}, 8'b11111001);
      tick();
    end
    hif.MemReadyM = 1; #1;
    chk("mw_rel_req", hif.MemReqM, 1);
    chk_ctl("mw_rel_ctl", 7'b1100110);
    tick();
    clr(); #1;
    chk("mw_done_req", hif.MemReqM, 0);
    chk("mw_done_err", hif.MemErr, 0);

    // ready arriving on the final timeout cycle wins
    hif.MemAccessM = 1;
    for (int i = 0; i < 15; i++) tick();
    #1;
    chk("to_edge_stall", hif.StallM, 1);
    hif.MemReadyM = 1; #1;
    chk("to_edge_rel", hif.StallM, 0);
    tick();
    clr(); #1;
    chk("to_edge_err", hif.MemErr, 0);

    // full timeout: 16 stalled cycles, then release with sticky error
    hif.MemAccessM = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("to_stall%0d", i), {hif.StallF, hif.StallM, hif.FlushW, hif.MemReqM}, 4'b1111);
      tick();
    end
    hif.MemAccessM = 0; #1;
    chk("to_release", hif.StallM, 0);
    chk("to_err", hif.MemErr, 1);
    tick(); tick();
    chk("to_err_sticky", hif.MemErr, 1);

    // reset while in WAIT
    hif.MemAccessM = 1;
    tick(); tick(); tick();
    rst_n = 0; #1;
    chk_ctl("rw_ctl", 7'b0000000);
    chk("rw_req", hif.MemReqM, 0);
    tick();
    rst_n = 1; hif.MemAccessM = 0; #1;
    chk("rw_err_clr", hif.MemErr, 0);
    chk("rw_idle_req", hif.MemReqM, 0);
    hif.MemAccessM = 1; hif.MemReadyM = 1; #1;
    chk("rw_idle_0stall", {hif.MemReqM, hif.StallM}, 2'b10);
    tick();
    hif.MemReadyM = 0; #1;
    chk("rw_idle_stall", hif.StallM, 1);
    tick();
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
